// File: rtl/alu_wide_seq_pkg.sv
// Shared types and constants for the 64-bit ALU sequencer.
// Request kind codes, FSM states, ALU opcodes and flag bit positions.
package alu_wide_seq_pkg;

    typedef enum logic [1:0] {
        KIND_ADD64 = 2'd0,
        KIND_SUB64 = 2'd1,
        KIND_CMP64 = 2'd2,
        KIND_CMPX  = 2'd3
    } req_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    localparam logic [4:0] OP_ALU_REG = 5'd0;
    localparam logic [4:0] ALUOP_ADD  = 5'd14;
    localparam logic [4:0] ALUOP_ADDC = 5'd15;
    localparam logic [4:0] ALUOP_SUB  = 5'd16;
    localparam logic [4:0] ALUOP_SUBB = 5'd17;

    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Only ADD64 adds; SUB64 and both compare codes subtract.
    function automatic logic kind_is_add(input logic [1:0] k);
        return k == KIND_ADD64;
    endfunction

    // Codes 2 and 3 are both compares.
    function automatic logic kind_is_cmp(input logic [1:0] k);
        return k[1];
    endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Runs 64-bit add/sub/compare as two passes on the 32-bit ALU, then fixes flags.
// Ports: req_* in (valid/ready), alu_* to/from the shared ALU, rsp_* out (valid/ready).
module alu_wide_seq
    import alu_wide_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic        req_keep_flags,
    output logic        alu_own,
    output logic [4:0]  alu_op,
    output logic [4:0]  alu_alu_op,
    output logic [31:0] alu_s1,
    output logic [31:0] alu_s2,
    output logic        alu_bubble,
    output logic        alu_flags_we,
    output logic [31:0] alu_flags_restore,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic [3:0]  rsp_flags
);

    state_e      state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [1:0]  kind_q, kind_d;
    logic        keep_q, keep_d;
    logic [3:0]  saved_q, saved_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        z_lo_q, z_lo_d;
    logic [3:0]  rflags_q, rflags_d;
    logic [3:0]  fix_flags;

    // 64-bit zero needs both halves zero; O/S/C come from the high pass.
    assign fix_flags = {alu_flags[FLAG_O],
                        alu_flags[FLAG_S],
                        z_lo_q & alu_flags[FLAG_Z],
                        alu_flags[FLAG_C]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI:   state_d = ST_FIX;
            ST_FIX:  state_d = ST_RSP;
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            kind_q   <= '0;
            keep_q   <= 1'b0;
            saved_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            z_lo_q   <= 1'b0;
            rflags_q <= '0;
        end else if (clk_en) begin
            a_q      <= a_d;
            b_q      <= b_d;
            kind_q   <= kind_d;
            keep_q   <= keep_d;
            saved_q  <= saved_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            z_lo_q   <= z_lo_d;
            rflags_q <= rflags_d;
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        kind_d   = kind_q;
        keep_d   = keep_q;
        saved_d  = saved_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        z_lo_d   = z_lo_q;
        rflags_d = rflags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    kind_d  = req_kind;
                    keep_d  = req_keep_flags;
                    saved_d = alu_flags;
                end
            end
            ST_LO: res_lo_d = alu_result;
            ST_HI: begin
                // alu_flags here still hold what the LO pass latched.
                z_lo_d   = alu_flags[FLAG_Z];
                res_hi_d = alu_result;
            end
            ST_FIX: rflags_d = fix_flags;
            default: ;
        endcase
    end

    always_comb begin
        req_ready         = 1'b0;
        alu_own           = 1'b0;
        alu_op            = OP_ALU_REG;
        alu_alu_op        = 5'd0;
        alu_s1            = '0;
        alu_s2            = '0;
        alu_bubble        = 1'b1;
        alu_flags_we      = 1'b0;
        alu_flags_restore = '0;
        rsp_valid         = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_LO: begin
                alu_own    = 1'b1;
                alu_bubble = 1'b0;
                alu_alu_op = kind_is_add(kind_q) ? ALUOP_ADD
                                                 : ALUOP_SUB;
                alu_s1     = a_q[31:0];
                alu_s2     = b_q[31:0];
            end
            ST_HI: begin
                alu_own    = 1'b1;
                alu_bubble = 1'b0;
                alu_alu_op = kind_is_add(kind_q) ? ALUOP_ADDC
                                                 : ALUOP_SUBB;
                alu_s1     = a_q[63:32];
                alu_s2     = b_q[63:32];
            end
            ST_FIX: begin
                alu_own      = 1'b1;
                alu_bubble   = 1'b0;
                alu_flags_we = 1'b1;
                alu_flags_restore = {28'b0,
                                     keep_q ? saved_q : fix_flags};
            end
            ST_RSP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_result = kind_is_cmp(kind_q) ? 64'b0
                                            : {res_hi_q, res_lo_q};
    assign rsp_flags  = rflags_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq with a 32-bit ALU model behind the ownership mux.
// Expected 64-bit results come from a direct 65-bit reference.
module tb_alu_wide_seq;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  flags;
        logic [3:0]  alu_after;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        req_keep_flags = 1'b0;
    logic        alu_own;
    logic [4:0]  alu_op, alu_alu_op;
    logic [31:0] alu_s1, alu_s2;
    logic        alu_bubble, alu_flags_we;
    logic [31:0] alu_flags_restore;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;

    logic        pipe_bubble = 1'b1;
    logic        pipe_flags_we = 1'b1;
    logic [31:0] pipe_restore = '0;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_wide_seq dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_a(req_a), .req_b(req_b),
        .req_keep_flags(req_keep_flags),
        .alu_own(alu_own), .alu_op(alu_op), .alu_alu_op(alu_alu_op),
        .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_bubble(alu_bubble),
        .alu_flags_we(alu_flags_we),
        .alu_flags_restore(alu_flags_restore),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    // Execute-stage ownership mux and a 32-bit ALU with a flag register.
    logic [4:0]  m_aop;
    logic [31:0] m_s1, m_s2, m_restore, s2x;
    logic        m_bubble, m_we, cin;
    logic [32:0] sum;
    logic [3:0]  nf, alu_flags_q;

    assign m_aop     = alu_own ? alu_alu_op : 5'd0;
    assign m_s1      = alu_own ? alu_s1 : 32'd0;
    assign m_s2      = alu_own ? alu_s2 : 32'd0;
    assign m_bubble  = alu_own ? alu_bubble : pipe_bubble;
    assign m_we      = alu_own ? alu_flags_we : pipe_flags_we;
    assign m_restore = alu_own ? alu_flags_restore : pipe_restore;

    always_comb begin
        s2x = m_s2;
        cin = 1'b0;
        case (m_aop)
            5'd15: cin = alu_flags_q[0];
            5'd16: begin s2x = ~m_s2; cin = 1'b1; end
            5'd17: begin s2x = ~m_s2; cin = alu_flags_q[0]; end
            default: ;
        endcase
        sum = {1'b0, m_s1} + {1'b0, s2x} + {32'd0, cin};
        nf  = {(m_s1[31] == s2x[31]) && (sum[31] != m_s1[31]),
               sum[31], sum[31:0] == 32'd0, sum[32]};
    end

    assign alu_result = sum[31:0];
    assign alu_flags  = alu_flags_q;

    always @(posedge clk) begin
        if (clk_en) begin
            if (m_we) alu_flags_q <= m_restore[3:0];
            else if (!m_bubble) alu_flags_q <= nf;
        end
    end

    function automatic exp_t ref64(input logic [1:0] k,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        exp_t e;
        logic [63:0] bx;
        logic [64:0] s;
        bx = (k == 2'd0) ? b : ~b;
        s = {1'b0, a} + {1'b0, bx} + ((k == 2'd0) ? 65'd0 : 65'd1);
        e.flags = {(a[63] == bx[63]) && (s[63] != a[63]),
                   s[63], s[63:0] == 64'd0, s[64]};
        e.res = k[1] ? 64'd0 : s[63:0];
        e.alu_after = e.flags;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one request; it is accepted on the next edge (DUT in IDLE).
    task automatic issue(input logic [1:0] k, input logic [63:0] a,
                         input logic [63:0] b, input logic keep);
        exp_t e;
        req_valid = 1'b1;
        req_kind = k;
        req_a = a;
        req_b = b;
        req_keep_flags = keep;
        e = ref64(k, a, b);
        if (keep) e.alu_after = alu_flags_q;
        sb_q.push_back(e);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        if (rsp_valid !== 1'b1) cyc = -1;
    endtask

    task automatic set_alu_flags(input logic [3:0] f);
        pipe_restore = {28'd0, f};
        pipe_flags_we = 1'b1;
        step();
        pipe_flags_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        pipe_flags_we = 1'b0;
        checks++;
        if ({req_ready, alu_own, alu_bubble, alu_flags_we, rsp_valid}
            !== 5'b10100) begin
            errors++;
            $display("FAIL reset_ctl got %b want 10100",
                     {req_ready, alu_own, alu_bubble,
                      alu_flags_we, rsp_valid});
        end
        checks++;
        if ({rsp_result, rsp_flags, alu_alu_op, alu_op, alu_s1,
             alu_s2, alu_flags_restore} !== '0) begin
            errors++;
            $display("FAIL reset_data res=%h fl=%b aop=%0d s1=%h",
                     rsp_result, rsp_flags, alu_alu_op, alu_s1);
        end
    endtask

    task automatic test_add_carry();
        exp_t e;
        int cyc;
        issue(2'd0, 64'h00000000_FFFFFFFF, 64'd1, 1'b0);
        checks++;
        if (alu_own !== 1'b1 || alu_alu_op !== 5'd14) begin
            errors++;
            $display("FAIL add_lo own=%b aop=%0d want 1 14",
                     alu_own, alu_alu_op);
        end
        step();
        checks++;
        if (alu_alu_op !== 5'd15 || alu_s1 !== 32'd0) begin
            errors++;
            $display("FAIL add_hi aop=%0d s1=%h want 15 0",
                     alu_alu_op, alu_s1);
        end
        wait_rsp(cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL add_latency got %0d want 2 more", cyc);
        end
        e = sb_q.pop_front();
        checks++;
        if (rsp_result !== 64'h00000001_00000000 ||
            rsp_result !== e.res || rsp_flags !== 4'b0000) begin
            errors++;
            $display("FAIL add_carry got %h/%b want %h/0000",
                     rsp_result, rsp_flags, e.res);
        end
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_idle rdy=%b vld=%b want 1 0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_sub_equal();
        exp_t e;
        int cyc;
        issue(2'd1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0);
        wait_rsp(cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc !== 3 || rsp_result !== 64'd0 || rsp_flags !== 4'b0011
            || rsp_flags !== e.flags) begin
            errors++;
            $display("FAIL sub_eq cyc=%0d got %h/%b want 0/0011",
                     cyc, rsp_result, rsp_flags);
        end
        checks++;
        if (alu_flags_q !== 4'b0011) begin
            errors++;
            $display("FAIL sub_eq_alu got %b want 0011", alu_flags_q);
        end
        step();
    endtask

    task automatic test_add_overflow();
        exp_t e;
        int cyc;
        issue(2'd0, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0);
        wait_rsp(cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc < 0 || rsp_result !== 64'h80000000_00000000 ||
            rsp_flags !== 4'b1100 || rsp_flags !== e.flags) begin
            errors++;
            $display("FAIL add_ovf got %h/%b want 8000000000000000/1100",
                     rsp_result, rsp_flags);
        end
        step();
    endtask

    task automatic test_keep_flags();
        exp_t e;
        int cyc;
        set_alu_flags(4'b1010);
        issue(2'd1, 64'h00000001_00000000, 64'd1, 1'b1);
        step();
        step();
        checks++;
        if (alu_flags_we !== 1'b1 ||
            alu_flags_restore !== 32'h0000000A) begin
            errors++;
            $display("FAIL keep_fix we=%b rst=%h want 1 0000000a",
                     alu_flags_we, alu_flags_restore);
        end
        wait_rsp(cyc);
        e = sb_q.pop_front();
        checks++;
        if (rsp_result !== 64'h00000000_FFFFFFFF ||
            rsp_flags !== 4'b0001 || rsp_flags !== e.flags) begin
            errors++;
            $display("FAIL keep_rsp got %h/%b want 00000000ffffffff/0001",
                     rsp_result, rsp_flags);
        end
        checks++;
        if (alu_flags_q !== 4'b1010 || alu_flags_q !== e.alu_after) begin
            errors++;
            $display("FAIL keep_alu got %b want 1010", alu_flags_q);
        end
        step();
    endtask

    task automatic test_stall();
        exp_t e;
        int cyc;
        int bad;
        issue(2'd1, 64'h00000005_00000003, 64'h00000002_00000007, 1'b0);
        step();
        clk_en = 1'b0;
        step();
        step();
        checks++;
        if (alu_own !== 1'b1 || alu_alu_op !== 5'd17 ||
            alu_s1 !== 32'd5 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold own=%b aop=%0d s1=%h rdy=%b",
                     alu_own, alu_alu_op, alu_s1, req_ready);
        end
        clk_en = 1'b1;
        rsp_ready = 1'b0;
        wait_rsp(cyc);
        e = sb_q.pop_front();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== e.res ||
                rsp_flags !== e.flags || req_ready !== 1'b0) bad++;
            step();
        end
        checks++;
        if (cyc < 0 || bad != 0) begin
            errors++;
            $display("FAIL stall_rsp bad=%0d got %h/%b want %h/%b",
                     bad, rsp_result, rsp_flags, e.res, e.flags);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== e.res ||
            alu_flags_q !== e.alu_after) begin
            errors++;
            $display("FAIL stall_alu got %h/%b want %h/%b",
                     rsp_result, alu_flags_q, e.res, e.alu_after);
        end
        rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc;
        issue(2'd0, 64'h00000001_80000000, 64'h00000002_80000000, 1'b0);
        void'(sb_q.pop_back());
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({req_ready, alu_own, alu_flags_we, rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid got %b want 1000",
                     {req_ready, alu_own, alu_flags_we, rsp_valid});
        end
        issue(2'd0, 64'h00000001_80000000, 64'h00000002_80000000, 1'b0);
        wait_rsp(cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc !== 3 || rsp_result !== 64'h00000004_00000000 ||
            rsp_flags !== e.flags) begin
            errors++;
            $display("FAIL rst_mid_add got %h/%b want %h/%b",
                     rsp_result, rsp_flags, e.res, e.flags);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int cyc;
        logic [63:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 1) b[63:32] = a[63:32];
            if (i % 4 == 2) b = a;
            if (i % 4 == 3) b[31:0] = a[31:0];
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, req_ready);
            end
            issue(2'(i % 4), a, b, 1'b0);
            wait_rsp(cyc);
            e = sb_q.pop_front();
            checks++;
            if (cyc !== 3 || rsp_result !== e.res ||
                rsp_flags !== e.flags) begin
                errors++;
                $display("FAIL b2b[%0d] k=%0d got %h/%b want %h/%b",
                         i, i % 4, rsp_result, rsp_flags, e.res, e.flags);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_equal();
        test_add_overflow();
        test_keep_flags();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
